addsub_bcd_display: RTL and testbench
=====================================

# addsub_bcd_display

Parametrised, sequential successor to the 8-bit adder/subtractor display path. Latches two WIDTH-bit operands on a start pulse and computes add or subtract in unsigned or two's-complement mode. Converts the true (non-wrapped) result to sign + BCD with a multi-cycle double-dabble FSM, then drives a DIGITS-wide multiplexed seven-segment display with leading-zero blanking and an out-of-range indication. Sits between the board switch/button inputs and the seven-segment/LED outputs of the top level.

## Interface
- WIDTH, 8: operand width (≥2).
- DIGITS, 4: number of seven-segment digits (≥2).
- REFRESH_DIV, 17: prescaler width; the digit advances every 2^REFRESH_DIV clocks.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; accepted only in IDLE.
- a  in  WIDTH  operand A, sampled on accepted start.
- b  in  WIDTH  operand B, sampled on accepted start.
- mode  in  1  0 = A+B, 1 = A−B; sampled on accepted start.
- signed_mode  in  1  1 = operands are two's complement; sampled on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when a new result/display value is committed.
- result  out  WIDTH  wrapped WIDTH-bit sum/difference.
- cout  out  1  adder carry out (subtract: 1 = no borrow).
- overflow  out  1  signed overflow, carry[WIDTH-1] ^ carry[WIDTH-2].
- negative  out  1  sign of true result.
- range_err  out  1  value does not fit on the display.
- an  out  DIGITS  digit enables, active-low, one-hot low.
- seg  out  7  segments, active-low, {g,f,e,d,c,b,a}.

## Operation
- FSM states: IDLE → CALC → CONVERT → IDLE.
- IDLE: start=1 latches a, b, mode, signed_mode; next state CALC. start in any other state is ignored (not queued).
- CALC (1 cycle): subtract = A + ~B + 1. The true result is computed in WIDTH+1 bits, with operands zero-extended (unsigned) or sign-extended (signed).
  - negative = MSB of true result (signed); mode & ~cout (unsigned).
  - magnitude M = |true result|, M_W = WIDTH+1 bits.
- CONVERT (M_W cycles): one double-dabble shift per cycle into a 4·DIGITS-bit BCD register. Each digit ≥5 gets +3 before the shift.
  - A 1 shifted out of the top digit sets a sticky too_big flag.
- After the last shift, range_err = too_big | (negative & top BCD digit ≠ 0).
- Commit at end of CONVERT: result, cout, overflow, negative, range_err and the display BCD/sign registers update together, done pulses, return to IDLE.
- Outputs hold their value between commits; the display shows the previous value during busy.
- Display digit i (0 = rightmost):
  - range_err=1: every digit shows 'E' (0000110).
  - else, negative and i = DIGITS-1: minus (0111111).
  - else, a leading-zero digit above digit 0 is blank (1111111); digit 0 always shows its value.
  - Decode 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- Refresh: the prescaler increments every clock; on wrap to 0 the digit index increments modulo DIGITS. an = ~(1 << index).

## Timing
- Reset (async assert, sync release): state IDLE; busy 0, done 0, result 0, cout 0, overflow 0, negative 0, range_err 0. BCD = 0, prescaler 0, index 0, an = ~1. Display shows "0" in digit 0 with all other digits blank.
- Start accepted at edge N: busy=1 from N+1; CALC during N+1; CONVERT during N+2..N+1+M_W; done=1 and new outputs visible in cycle N+2+M_W. Latency is M_W+2 clocks; WIDTH=8 gives 11.
- busy falls in the same cycle done pulses. A start in that cycle is accepted, so back-to-back throughput is one result per M_W+2 clocks.
- Reset mid-operation aborts: no done pulse, outputs return to their reset values.
- Operand/mode changes after acceptance have no effect on the current operation.

## Test plan
- WIDTH=8, DIGITS=4, unsigned: 200+100 → result 0x2C, cout 1, negative 0, range_err 0. Display "300" with the top digit blank. done exactly 11 clocks after start.
- Unsigned: 5−10 → result 0xFB, cout 0, negative 1. Display '-', blank, blank, '5'.
- Signed: 0x80−0x01 → result 0x7F, overflow 1, negative 1. Display "-129".
- DIGITS=2, unsigned: 99+1 → range_err 1, both digits 'E'. Then 98+1 → range_err 0, display "99".
- start pulsed during busy → ignored, exactly one done. rst asserted mid-CONVERT → busy 0, no done, display "0".
- REFRESH_DIV=2 → an sequence 1110, 1101, 1011, 0111, changing every 4 clocks and wrapping.

Source files
------------

// File: rtl/addsub_bcd_display.sv
`timescale 1ns/1ps
// addsub_bcd_display: latched add/subtract with sign + BCD conversion
// (double dabble) driving a multiplexed seven-segment display.
module addsub_bcd_display #(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              mode,
    input  logic              signed_mode,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic              cout,
    output logic              overflow,
    output logic              negative,
    output logic              range_err,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg
);
    localparam int MW = WIDTH + 1;
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(MW + 1);
    localparam int IW = $clog2(DIGITS);
    localparam logic [WIDTH:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, CALC, CONVERT} state_t;

    state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic mode_q, mode_d, sgn_q, sgn_d;
    logic busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] res_c_q, res_c_d;
    logic cout_c_q, cout_c_d, ovf_c_q, ovf_c_d, neg_c_q, neg_c_d;
    logic [MW-1:0] mag_q, mag_d;
    logic [BW-1:0] bcd_q, bcd_d;
    logic too_big_q, too_big_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic cout_q, cout_d, overflow_q, overflow_d;
    logic negative_q, negative_d, range_err_q, range_err_d;
    logic [BW-1:0] disp_q, disp_d;
    logic [REFRESH_DIV-1:0] pre_q, pre_d;
    logic [IW-1:0] idx_q, idx_d;

    logic [WIDTH-1:0] bx;
    logic [WIDTH:0] wsum, a_ext, b_ext, tsum, mag_c;
    logic cin_msb, neg_c;

    // Wrapped WIDTH-bit adder for flags, plus a WIDTH+1-bit true result.
    assign bx      = mode_q ? ~b_q : b_q;
    assign wsum    = {1'b0, a_q} + {1'b0, bx} + {{WIDTH{1'b0}}, mode_q};
    assign cin_msb = a_q[WIDTH-1] ^ bx[WIDTH-1] ^ wsum[WIDTH-1];
    assign a_ext   = {sgn_q & a_q[WIDTH-1], a_q};
    assign b_ext   = {sgn_q & b_q[WIDTH-1], b_q};
    assign tsum    = a_ext + (mode_q ? ~b_ext : b_ext)
                   + {{WIDTH{1'b0}}, mode_q};
    assign neg_c   = sgn_q ? tsum[WIDTH] : (mode_q & ~wsum[WIDTH]);
    assign mag_c   = neg_c ? (~tsum + ONE) : tsum;

    logic [BW-1:0] adj;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        mode_d      = mode_q;
        sgn_d       = sgn_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        res_c_d     = res_c_q;
        cout_c_d    = cout_c_q;
        ovf_c_d     = ovf_c_q;
        neg_c_d     = neg_c_q;
        mag_d       = mag_q;
        bcd_d       = bcd_q;
        too_big_d   = too_big_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        cout_d      = cout_q;
        overflow_d  = overflow_q;
        negative_d  = negative_q;
        range_err_d = range_err_q;
        disp_d      = disp_q;
        pre_d       = pre_q + REFRESH_DIV'(1);
        idx_d       = idx_q;
        if (pre_q == '1) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    mode_d  = mode;
                    sgn_d   = signed_mode;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                res_c_d   = wsum[WIDTH-1:0];
                cout_c_d  = wsum[WIDTH];
                ovf_c_d   = wsum[WIDTH] ^ cin_msb;
                neg_c_d   = neg_c;
                mag_d     = mag_c;
                bcd_d     = '0;
                too_big_d = 1'b0;
                cnt_d     = '0;
                state_d   = CONVERT;
            end
            CONVERT: begin
                bcd_d     = {adj[BW-2:0], mag_q[MW-1]};
                mag_d     = mag_q << 1;
                too_big_d = too_big_q | adj[BW-1];
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CW'(MW - 1)) begin
                    result_d    = res_c_q;
                    cout_d      = cout_c_q;
                    overflow_d  = ovf_c_q;
                    negative_d  = neg_c_q;
                    range_err_d = too_big_d
                                | (neg_c_q & (bcd_d[BW-1 -: 4] != 4'd0));
                    disp_d      = bcd_d;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= 1'b0;
            sgn_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_c_q     <= '0;
            cout_c_q    <= 1'b0;
            ovf_c_q     <= 1'b0;
            neg_c_q     <= 1'b0;
            mag_q       <= '0;
            bcd_q       <= '0;
            too_big_q   <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            overflow_q  <= 1'b0;
            negative_q  <= 1'b0;
            range_err_q <= 1'b0;
            disp_q      <= '0;
            pre_q       <= '0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            sgn_q       <= sgn_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            res_c_q     <= res_c_d;
            cout_c_q    <= cout_c_d;
            ovf_c_q     <= ovf_c_d;
            neg_c_q     <= neg_c_d;
            mag_q       <= mag_d;
            bcd_q       <= bcd_d;
            too_big_q   <= too_big_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            cout_q      <= cout_d;
            overflow_q  <= overflow_d;
            negative_q  <= negative_d;
            range_err_q <= range_err_d;
            disp_q      <= disp_d;
            pre_q       <= pre_d;
            idx_q       <= idx_d;
        end
    end

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    dec7 = 7'b1000000;
            4'd1:    dec7 = 7'b1111001;
            4'd2:    dec7 = 7'b0100100;
            4'd3:    dec7 = 7'b0110000;
            4'd4:    dec7 = 7'b0011001;
            4'd5:    dec7 = 7'b0010010;
            4'd6:    dec7 = 7'b0000010;
            4'd7:    dec7 = 7'b1111000;
            4'd8:    dec7 = 7'b0000000;
            4'd9:    dec7 = 7'b0010000;
            default: dec7 = 7'b1111111;
        endcase
    endfunction

    // lz[i] is set when digit i and every digit above it are zero.
    logic [DIGITS-1:0] lz;
    logic run;
    logic [3:0] cur;

    always_comb begin
        run = 1'b1;
        lz  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run   = run & (disp_q[4*i +: 4] == 4'd0);
            lz[i] = run;
        end
    end

    assign cur = disp_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        if (range_err_q) begin
            seg = 7'b0000110;
        end else if (negative_q && idx_q == IW'(DIGITS - 1)) begin
            seg = 7'b0111111;
        end else if (idx_q != '0 && lz[idx_q]) begin
            seg = 7'b1111111;
        end else begin
            seg = dec7(cur);
        end
    end

    assign an        = ~(DIGITS'(1) << idx_q);
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign cout      = cout_q;
    assign overflow  = overflow_q;
    assign negative  = negative_q;
    assign range_err = range_err_q;

endmodule

// File: tb/tb_addsub_bcd_display.sv
`timescale 1ns/1ps
// Bench for addsub_bcd_display: 4-digit and 2-digit instances share
// stimulus and are compared against an integer arithmetic model.
module tb_addsub_bcd_display;
    logic clk = 1'b0;
    logic rst, start, mode, signed_mode;
    logic [7:0] a, b;

    logic busy4, done4, cout4, ovf4, neg4, rerr4;
    logic [7:0] res4;
    logic [3:0] an4;
    logic [6:0] seg4;
    logic busy2, done2, cout2, ovf2, neg2, rerr2;
    logic [7:0] res2;
    logic [1:0] an2;
    logic [6:0] seg2;

    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    addsub_bcd_display #(.WIDTH(8), .DIGITS(4), .REFRESH_DIV(2)) u_d4 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .mode(mode), .signed_mode(signed_mode),
        .busy(busy4), .done(done4), .result(res4), .cout(cout4),
        .overflow(ovf4), .negative(neg4), .range_err(rerr4),
        .an(an4), .seg(seg4)
    );

    addsub_bcd_display #(.WIDTH(8), .DIGITS(2), .REFRESH_DIV(2)) u_d2 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .mode(mode), .signed_mode(signed_mode),
        .busy(busy2), .done(done2), .result(res2), .cout(cout2),
        .overflow(ovf2), .negative(neg2), .range_err(rerr2),
        .an(an2), .seg(seg2)
    );

    localparam logic [6:0] SEG_TBL [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef struct {
        logic [7:0] res;
        bit cout;
        bit ovf;
        bit neg;
        int mag;
    } exp_t;

    function automatic exp_t model(int au, int bu, bit m, bit s);
        exp_t e;
        int sa, sb, av, bv, tv, st;
        sa = (au >= 128) ? au - 256 : au;
        sb = (bu >= 128) ? bu - 256 : bu;
        av = s ? sa : au;
        bv = s ? sb : bu;
        tv = m ? av - bv : av + bv;
        st = m ? sa - sb : sa + sb;
        e.res  = 8'(tv);
        e.cout = m ? (au >= bu) : (au + bu > 255);
        e.ovf  = (st > 127) || (st < -128);
        e.neg  = (tv < 0);
        e.mag  = (tv < 0) ? -tv : tv;
        return e;
    endfunction

    function automatic int pow10(int n);
        int p = 1;
        for (int k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    function automatic bit exp_rerr(int mag, bit neg, int nd);
        return neg ? (mag >= pow10(nd - 1)) : (mag >= pow10(nd));
    endfunction

    function automatic logic [6:0] exp_seg(int mag, bit neg, int nd, int i);
        if (exp_rerr(mag, neg, nd)) return 7'b0000110;
        if (neg && i == nd - 1) return 7'b0111111;
        if (i > 0 && mag < pow10(i)) return 7'b1111111;
        return SEG_TBL[(mag / pow10(i)) % 10];
    endfunction

    function automatic int active(logic [3:0] v, int nd);
        int idx = -1;
        int n = 0;
        for (int i = 0; i < nd; i++) begin
            if (v[i] == 1'b0) begin
                idx = i;
                n++;
            end
        end
        return (n == 1) ? idx : -1;
    endfunction

    task automatic test_display(int mag, bit neg, string tag);
        int i4, i2;
        for (int c = 0; c < 16; c++) begin
            i4 = active(an4, 4);
            i2 = active({2'b11, an2}, 2);
            checks++;
            if (i4 < 0 || seg4 !== exp_seg(mag, neg, 4, i4)) begin
                fails++;
                $display("FAIL %s disp4: an=%b seg=%b want %b", tag, an4,
                         seg4, (i4 < 0) ? 7'bx : exp_seg(mag, neg, 4, i4));
            end
            checks++;
            if (i2 < 0 || seg2 !== exp_seg(mag, neg, 2, i2)) begin
                fails++;
                $display("FAIL %s disp2: an=%b seg=%b want %b", tag, an2,
                         seg2, (i2 < 0) ? 7'bx : exp_seg(mag, neg, 2, i2));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy4, done4, res4, cout4, ovf4, neg4, rerr4} !== 13'd0) begin
            fails++;
            $display("FAIL reset outs4: got %b want 0",
                     {busy4, done4, res4, cout4, ovf4, neg4, rerr4});
        end
        checks++;
        if ({busy2, done2, res2, cout2, ovf2, neg2, rerr2} !== 13'd0) begin
            fails++;
            $display("FAIL reset outs2: got %b want 0",
                     {busy2, done2, res2, cout2, ovf2, neg2, rerr2});
        end
        checks++;
        if (an4 !== 4'b1110 || seg4 !== 7'b1000000) begin
            fails++;
            $display("FAIL reset disp4: an=%b seg=%b want 1110 1000000",
                     an4, seg4);
        end
        checks++;
        if (an2 !== 2'b10 || seg2 !== 7'b1000000) begin
            fails++;
            $display("FAIL reset disp2: an=%b seg=%b want 10 1000000",
                     an2, seg2);
        end
    endtask

    task automatic test_refresh();
        logic [3:0] one4 = 4'b0001;
        logic [3:0] e4;
        logic [1:0] one2 = 2'b01;
        logic [1:0] e2;
        for (int k = 0; k < 40; k++) begin
            e4 = ~(one4 << ((k / 4) % 4));
            e2 = ~(one2 << ((k / 4) % 2));
            checks++;
            if (an4 !== e4 || an2 !== e2) begin
                fails++;
                $display("FAIL refresh k=%0d: an4=%b an2=%b want %b %b",
                         k, an4, an2, e4, e2);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_op(int av, int bv, bit m, bit s, string tag);
        exp_t e;
        int cyc;
        e = model(av, bv, m, s);
        @(negedge clk);
        a = 8'(av);
        b = 8'(bv);
        mode = m;
        signed_mode = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        mode = ~m;
        signed_mode = ~s;
        checks++;
        if (busy4 !== 1'b1 || busy2 !== 1'b1) begin
            fails++;
            $display("FAIL %s busy: got %b%b want 11", tag, busy4, busy2);
        end
        cyc = 1;
        while (done4 !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 11 || done2 !== 1'b1) begin
            fails++;
            $display("FAIL %s latency: got %0d done2=%b want 11", tag, cyc,
                     done2);
        end
        checks++;
        if (res4 !== e.res || res2 !== e.res) begin
            fails++;
            $display("FAIL %s result: got %h/%h want %h", tag, res4, res2,
                     e.res);
        end
        checks++;
        if ({cout4, ovf4, neg4} !== {e.cout, e.ovf, e.neg}
            || {cout2, ovf2, neg2} !== {e.cout, e.ovf, e.neg}) begin
            fails++;
            $display("FAIL %s flags: got %b/%b want %b", tag,
                     {cout4, ovf4, neg4}, {cout2, ovf2, neg2},
                     {e.cout, e.ovf, e.neg});
        end
        checks++;
        if (rerr4 !== exp_rerr(e.mag, e.neg, 4)
            || rerr2 !== exp_rerr(e.mag, e.neg, 2)) begin
            fails++;
            $display("FAIL %s range_err: got %b/%b want %b/%b", tag, rerr4,
                     rerr2, exp_rerr(e.mag, e.neg, 4),
                     exp_rerr(e.mag, e.neg, 2));
        end
        checks++;
        if (busy4 !== 1'b0) begin
            fails++;
            $display("FAIL %s busy at done: got %b want 0", tag, busy4);
        end
        @(negedge clk);
        checks++;
        if (done4 !== 1'b0 || done2 !== 1'b0) begin
            fails++;
            $display("FAIL %s done pulse: got %b%b want 00", tag, done4,
                     done2);
        end
        test_display(e.mag, e.neg, tag);
    endtask

    task automatic test_directed();
        test_op(200, 100, 1'b0, 1'b0, "u_200p100");
        test_op(5, 10, 1'b1, 1'b0, "u_5m10");
        test_op(8'h80, 8'h01, 1'b1, 1'b1, "s_80m01");
        test_op(99, 1, 1'b0, 1'b0, "u_99p1");
        test_op(98, 1, 1'b0, 1'b0, "u_98p1");
        test_op(255, 255, 1'b0, 1'b0, "u_max_add");
        test_op(8'h80, 8'h7F, 1'b1, 1'b1, "s_min_sub");
        test_op(0, 0, 1'b0, 1'b0, "u_zero");
        test_op(8'h7F, 8'h7F, 1'b0, 1'b1, "s_ovf_add");
        test_op(8'hFF, 8'h01, 1'b0, 1'b1, "s_m1p1");
        test_op(0, 255, 1'b1, 1'b0, "u_0m255");
    endtask

    task automatic test_back_to_back();
        exp_t e1, e2;
        int cyc;
        e1 = model(123, 45, 1'b1, 1'b0);
        e2 = model(8'hF0, 8'h20, 1'b0, 1'b1);
        @(negedge clk);
        a = 8'd123;
        b = 8'd45;
        mode = 1'b1;
        signed_mode = 1'b0;
        start = 1'b1;
        @(negedge clk);
        a = 8'hF0;
        b = 8'h20;
        mode = 1'b0;
        signed_mode = 1'b1;
        cyc = 1;
        while (done4 !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 11 || res4 !== e1.res || neg4 !== e1.neg) begin
            fails++;
            $display("FAIL b2b first: cyc=%0d res=%h neg=%b want 11 %h %b",
                     cyc, res4, neg4, e1.res, e1.neg);
        end
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done4 !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 11 || res4 !== e2.res || neg4 !== e2.neg) begin
            fails++;
            $display("FAIL b2b second: cyc=%0d res=%h neg=%b want 11 %h %b",
                     cyc, res4, neg4, e2.res, e2.neg);
        end
        @(negedge clk);
        test_display(e2.mag, e2.neg, "b2b");
    endtask

    task automatic test_start_during_busy();
        exp_t e;
        int nd = 0;
        logic [7:0] r = 8'h00;
        e = model(17, 25, 1'b0, 1'b0);
        @(negedge clk);
        a = 8'd17;
        b = 8'd25;
        mode = 1'b0;
        signed_mode = 1'b0;
        start = 1'b1;
        @(negedge clk);
        a = 8'd200;
        b = 8'd3;
        for (int c = 1; c <= 30; c++) begin
            if (done4 === 1'b1) begin
                nd++;
                r = res4;
            end
            start = (c == 3 || c == 6 || c == 9);
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (nd != 1 || r !== e.res) begin
            fails++;
            $display("FAIL busy_start: dones=%0d res=%h want 1 %h", nd, r,
                     e.res);
        end
    endtask

    task automatic test_reset_mid();
        int nd = 0;
        @(negedge clk);
        a = 8'd200;
        b = 8'd100;
        mode = 1'b0;
        signed_mode = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy4, done4, res4, neg4, rerr4} !== 12'd0 || an4 !== 4'b1110)
        begin
            fails++;
            $display("FAIL rst_mid outs: got %b an=%b want 0 1110",
                     {busy4, done4, res4, neg4, rerr4}, an4);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done4 === 1'b1 || busy4 === 1'b1) nd++;
            @(negedge clk);
        end
        checks++;
        if (nd != 0) begin
            fails++;
            $display("FAIL rst_mid activity: got %0d busy/done cycles want 0",
                     nd);
        end
        test_display(0, 1'b0, "rst_mid");
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            test_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    "random");
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = 8'd0;
        b = 8'd0;
        mode = 1'b0;
        signed_mode = 1'b0;
        test_reset();
        test_refresh();
        test_directed();
        test_back_to_back();
        test_start_during_busy();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
